// File: rtl/cdc_hs_tx.sv
`timescale 1ns/1ps
// Source side of a 4-phase req/ack handshake carrying a DW-bit word to another
// clock domain, with a per-phase stall counter and a sticky timeout flag.
module cdc_hs_tx #(
    parameter int DW     = 32,
    parameter int TO_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          req_o,
    output logic [DW-1:0] data_o,
    input  logic          ack_i,
    output logic          busy,
    output logic          done,
    input  logic          err_clr,
    output logic          timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } state_t;

    localparam logic [15:0] TO_LIM = 16'(TO_CYC);

    state_t        state_q;
    logic          ack_meta_q;
    logic          ack_s_q;
    logic          req_q;
    logic [DW-1:0] data_q;
    logic          done_q;
    logic          err_q;
    logic          err_d;
    logic [15:0]   cnt_q;
    logic [15:0]   cnt_d;
    logic          accept;
    logic          phase_change;

    // ack_i is asynchronous; only the second flop's output is used anywhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= ack_i;
            ack_s_q    <= ack_meta_q;
        end
    end

    assign in_ready = (state_q == IDLE) && !ack_s_q;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_q  <= in_data;
                        req_q   <= 1'b1;
                        state_q <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (ack_s_q) begin
                        req_q   <= 1'b0;
                        state_q <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!ack_s_q) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign phase_change = accept
                       || ((state_q == WAIT_HI) && ack_s_q)
                       || ((state_q == WAIT_LO) && !ack_s_q);

    // The flag is only reported, never acted on: a slow remote still completes.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == IDLE) || phase_change) begin
            cnt_d = '0;
        end else if (cnt_q != TO_LIM) begin
            cnt_d = cnt_q + 16'd1;
        end
        err_d = err_q;
        if (cnt_d == TO_LIM) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign req_o       = req_q;
    assign data_o      = data_q;
    assign done        = done_q;
    assign timeout_err = err_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_hs_tx.sv
`timescale 1ns/1ps
// Bench for cdc_hs_tx: directed scenarios with literal expectations, then
// randomised transfers against a cycle-level behavioural model and scoreboard.
module tb_cdc_hs_tx;

    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          req_o;
    logic [DW-1:0] data_o;
    logic          ack_i;
    logic          busy;
    logic          done;
    logic          err_clr = 1'b0;
    logic          timeout_err;

    logic ack_man = 1'b0;
    logic ack_auto = 1'b0;
    logic auto_en = 1'b0;
    int   ack_max = 0;
    assign ack_i = auto_en ? ack_auto : ack_man;

    cdc_hs_tx #(.DW(DW), .TO_CYC(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .req_o(req_o), .data_o(data_o), .ack_i(ack_i),
        .busy(busy), .done(done), .err_clr(err_clr), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Behavioural model: ack is seen two edges late; a word waits for ack high,
    // then for ack low; each waiting phase has an age that trips the flag at TO.
    int            m_phase;
    int            m_age;
    int            m_next;
    int            m_acc = 0;
    logic          m_h1, m_h2, m_acks;
    logic          m_req, m_done, m_err;
    logic [DW-1:0] m_data;
    logic [DW-1:0] exp_q[$];

    task automatic m_reset();
        m_phase = 0; m_age = 0; m_h1 = 0; m_h2 = 0;
        m_req = 0; m_done = 0; m_err = 0; m_data = '0;
        exp_q.delete();
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_reset();
            end else begin
                m_acks = m_h2;
                m_done = 0;
                m_next = m_phase;
                if (m_phase == 0 && in_valid && !m_acks) begin
                    m_data = in_data;
                    m_req  = 1;
                    m_next = 1;
                    exp_q.push_back(in_data);
                    m_acc++;
                end else if (m_phase == 1 && m_acks) begin
                    m_req  = 0;
                    m_next = 2;
                end else if (m_phase == 2 && !m_acks) begin
                    m_next = 0;
                    m_done = 1;
                end
                if (m_next != m_phase || m_next == 0) m_age = 0;
                else if (m_age < TO) m_age++;
                m_phase = m_next;
                if (m_age == TO) m_err = 1;
                else if (err_clr) m_err = 0;
                m_h2 = m_h1;
                m_h1 = ack_i;
            end
        end
    end

    // Per-cycle compare, scoreboard on each request rise, and req/data hold rule.
    bit            cmp_en = 0;
    logic          prev_req = 0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] sb_word;
    initial begin
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                prev_req  = 0;
                prev_data = '0;
            end else if (cmp_en) begin
                check("req_o", req_o, m_req);
                check("data_o", data_o, m_data);
                check("in_ready", in_ready, (m_phase == 0) && !m_h2);
                check("busy", busy, m_phase != 0);
                check("done", done, m_done);
                check("timeout_err", timeout_err, m_err);
                if (done) done_cnt++;
                if (req_o && !prev_req) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL sb_extra: got word 0x%0h want none", data_o);
                    end else begin
                        sb_word = exp_q.pop_front();
                        check("sb_word", data_o, sb_word);
                    end
                end
                check("hold", (data_o !== prev_data) && !(req_o && !prev_req), 1'b0);
                prev_req  = req_o;
                prev_data = data_o;
            end
        end
    end

    // Remote side: raises ack some cycles after req, at an offset that never
    // coincides with a clock edge, and drops it after req falls.
    int r_d, r_n;
    initial begin
        forever begin
            @(negedge clk);
            if (auto_en && req_o) begin
                r_d = $urandom_range(0, ack_max);
                repeat (r_d) @(negedge clk);
                r_d = $urandom_range(1, 8);
                #(r_d >= 5 ? r_d + 1 : r_d);
                ack_auto = 1'b1;
                r_n = 0;
                while (req_o && r_n < 100) begin @(negedge clk); r_n++; end
                r_d = $urandom_range(0, ack_max);
                repeat (r_d) @(negedge clk);
                r_d = $urandom_range(1, 8);
                #(r_d >= 5 ? r_d + 1 : r_d);
                ack_auto = 1'b0;
            end
        end
    end

    task automatic send(input logic [DW-1:0] w, input bit scramble);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 400) begin
            step();
            n++;
            if (scramble) in_data = $urandom;
        end
        if (n >= 400) begin
            n_cmp++; n_bad++;
            $display("FAIL send_wait: got no in_ready in %0d cycles want ready", n);
        end
        step();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || req_o) && n < 400) begin step(); n++; end
        if (n >= 400) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_wait: got busy after %0d cycles want idle", n);
        end
        repeat (3) step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    int d0, a0;
    initial begin
        repeat (2) step();
        check("rst_req", req_o, 0);
        check("rst_data", data_o, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", timeout_err, 0);
        check("rst_ready", in_ready, 1);

        // single transfer, accepted on the first edge after reset release
        rst = 0; cmp_en = 1;
        in_valid = 1; in_data = 32'hA5A5_0001;
        step();
        in_valid = 0; in_data = '0;
        check("t1_req", req_o, 1);
        check("t1_data", data_o, 32'hA5A5_0001);
        check("t1_ready", in_ready, 0);
        check("m_t1_data", m_data, 32'hA5A5_0001);
        repeat (2) step();
        ack_man = 1;
        repeat (2) step();
        check("t1_req_hold", req_o, 1);
        step();
        check("t1_req_drop", req_o, 0);
        check("t1_data_keep", data_o, 32'hA5A5_0001);
        check("m_t1_req", m_req, 0);
        repeat (4) step();
        ack_man = 0;
        repeat (2) step();
        check("t1_done_early", done, 0);
        step();
        check("t1_done", done, 1);
        check("t1_busy_end", busy, 0);
        check("t1_ready_end", in_ready, 1);
        step();
        check("t1_done_once", done, 0);

        // stall timeout with sticky flag and set-over-clear
        in_valid = 1; in_data = 32'h0000_BEEF;
        step();
        in_valid = 0;
        repeat (7) step();
        check("to_err_before", timeout_err, 0);
        step();
        check("to_err_set", timeout_err, 1);
        check("to_req_kept", req_o, 1);
        check("m_to_err", m_err, 1);
        err_clr = 1;
        step();
        err_clr = 0;
        check("to_set_wins", timeout_err, 1);
        ack_man = 1;
        repeat (3) step();
        check("to_req_drop", req_o, 0);
        ack_man = 0;
        repeat (3) step();
        check("to_done", done, 1);
        check("to_sticky", timeout_err, 1);
        err_clr = 1;
        step();
        err_clr = 0;
        check("to_clear", timeout_err, 0);

        // asynchronous reset while waiting for ack high
        in_valid = 1; in_data = 32'h1234_5678;
        step();
        in_valid = 0;
        step();
        check("ar_busy_pre", busy, 1);
        #2 rst = 1;
        #1;
        check("ar_req", req_o, 0);
        check("ar_busy", busy, 0);
        check("ar_data", data_o, 0);
        #1 rst = 0;
        d0 = done_cnt;
        repeat (4) step();
        check("ar_no_done", done_cnt - d0, 0);

        // remote asserts ack while idle
        ack_man = 1;
        repeat (2) step();
        check("pv_ready_low", in_ready, 0);
        in_valid = 1; in_data = 32'h0000_DEAD;
        repeat (3) step();
        check("pv_req", req_o, 0);
        check("pv_busy", busy, 0);
        in_valid = 0;
        ack_man = 0;
        step();
        check("pv_ready_1edge", in_ready, 0);
        step();
        check("pv_ready_back", in_ready, 1);

        // back-to-back with a fast remote
        auto_en = 1; ack_max = 0;
        d0 = done_cnt;
        send(32'h1, 0);
        send(32'h2, 0);
        send(32'h3, 0);
        in_valid = 0;
        wait_idle();
        check("b2b_dones", done_cnt - d0, 3);
        check("m_b2b_last", m_data, 32'h3);

        // randomised traffic and ack timing
        ack_max = 10;
        d0 = done_cnt; a0 = m_acc;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) step();
            if ($urandom_range(0, 15) == 0) begin
                err_clr = 1; step(); err_clr = 0;
            end
            send($urandom, 1'($urandom_range(0, 1)));
            in_valid = 0;
        end
        wait_idle();
        check("rnd_accepts", m_acc - a0, 1000);
        check("rnd_dones", done_cnt - d0, m_acc - a0);
        check("rnd_sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
